// File: rtl/i2c_reg_slave_if.sv
// Register-side port bundle of the I2C register target.
// master: the I2C block driving pointer/strobes; slave: the register file.
interface i2c_reg_slave_if;
  logic [7:0] oREG_ADDR;
  logic [7:0] oREG_WDATA;
  logic       oREG_WE;
  logic       oREG_RE;
  logic       oBUSY;
  logic [7:0] iREG_RDATA;

  modport master (
    output oREG_ADDR, oREG_WDATA,
    output oREG_WE, oREG_RE, oBUSY,
    input  iREG_RDATA
  );

  modport slave (
    input  oREG_ADDR, oREG_WDATA,
    input  oREG_WE, oREG_RE, oBUSY,
    output iREG_RDATA
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C register target: oversampled SCL/SDA, address match, write strobes.
// Ports: iCLK, iRST_N, I2C_SCLK, I2C_SDAT (open drain), regIf (master).
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int FILTER_LEN = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic I2C_SCLK,
  inout  wire  I2C_SDAT,
  i2c_reg_slave_if.master regIf
);
  localparam logic [3:0] CMAX = 4'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0] s1, s2, filt, prev;
  logic [1:0][3:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1   <= 2'b11;
      s2   <= 2'b11;
      filt <= 2'b11;
      prev <= 2'b11;
      cnt  <= '0;
    end else begin
      s1   <= {I2C_SCLK, I2C_SDAT};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  logic sclF, sdaF, sclQ, sdaQ;
  logic sclRise, sclFall, startEv, stopEv;
  assign sclF = filt[1];
  assign sdaF = filt[0];
  assign sclQ = prev[1];
  assign sdaQ = prev[0];
  assign sclRise = sclF & ~sclQ;
  assign sclFall = ~sclF & sclQ;
  assign startEv = sclF & sclQ & sdaQ & ~sdaF;
  assign stopEv  = sclF & sclQ & ~sdaQ & sdaF;

  state_t state, stateN;
  logic [3:0] bitCnt, bitCntN;
  logic [7:0] shift, shiftN, tx, txN;
  logic [7:0] regAddr, addrN, wdata, wdataN;
  logic sdaOe, sdaOeN, we, weN, reC;
  logic busy, busyN, rw, rwN;
  logic incPend, incPendN;
  logic [7:0] rxByte;

  assign rxByte = {shift[6:0], sdaF};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      bitCnt  <= '0;
      shift   <= '0;
      tx      <= '0;
      regAddr <= '0;
      wdata   <= '0;
      sdaOe   <= 1'b0;
      we      <= 1'b0;
      busy    <= 1'b0;
      rw      <= 1'b0;
      incPend <= 1'b0;
    end else begin
      state   <= stateN;
      bitCnt  <= bitCntN;
      shift   <= shiftN;
      tx      <= txN;
      regAddr <= addrN;
      wdata   <= wdataN;
      sdaOe   <= sdaOeN;
      we      <= weN;
      busy    <= busyN;
      rw      <= rwN;
      incPend <= incPendN;
    end
  end

  always_comb begin
    stateN   = state;
    bitCntN  = bitCnt;
    shiftN   = shift;
    txN      = tx;
    addrN    = regAddr;
    wdataN   = wdata;
    sdaOeN   = sdaOe;
    weN      = 1'b0;
    reC      = 1'b0;
    busyN    = busy;
    rwN      = rw;
    incPendN = 1'b0;
    // post-write pointer bump lands the cycle after the WE strobe
    if (incPend) addrN = regAddr + 8'd1;
    if (startEv) begin
      stateN  = ADDR;
      bitCntN = '0;
      sdaOeN  = 1'b0;
      busyN   = 1'b0;
    end else if (stopEv) begin
      stateN = IDLE;
      sdaOeN = 1'b0;
      busyN  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, SUB, WDATA: begin
          if (sclRise) begin
            shiftN  = rxByte;
            bitCntN = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              bitCntN = '0;
              if (state == ADDR) begin
                if (rxByte[7:1] == SLAVE_ADDR) begin
                  busyN  = 1'b1;
                  rwN    = rxByte[0];
                  stateN = ADDR_ACK;
                end else begin
                  stateN = IGNORE;
                end
              end else if (state == SUB) begin
                addrN  = rxByte;
                stateN = SUB_ACK;
              end else begin
                wdataN   = rxByte;
                weN      = 1'b1;
                incPendN = 1'b1;
                stateN   = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          // sdaOe doubles as the ACK phase: first fall pulls, second releases
          if (sclFall) begin
            if (!sdaOe) begin
              sdaOeN = 1'b1;
            end else begin
              sdaOeN = 1'b0;
              if (state != ADDR_ACK) begin
                stateN = WDATA;
              end else if (!rw) begin
                stateN = SUB;
              end else begin
                reC     = 1'b1;
                txN     = regIf.iREG_RDATA;
                sdaOeN  = ~regIf.iREG_RDATA[7];
                bitCntN = 4'd1;
                stateN  = RDATA;
              end
            end
          end
        end
        RDATA: begin
          if (sclFall) begin
            if (bitCnt == 4'd8) begin
              sdaOeN  = 1'b0;
              bitCntN = '0;
              stateN  = MACK;
            end else begin
              txN     = {tx[6:0], 1'b0};
              sdaOeN  = ~tx[6];
              bitCntN = bitCnt + 4'd1;
            end
          end
        end
        MACK: begin
          if (sclRise) begin
            if (!sdaF) begin
              addrN   = regAddr + 8'd1;
              bitCntN = 4'd1;
            end else begin
              stateN = IGNORE;
            end
          end else if (sclFall && bitCnt == 4'd1) begin
            reC     = 1'b1;
            txN     = regIf.iREG_RDATA;
            sdaOeN  = ~regIf.iREG_RDATA[7];
            bitCntN = 4'd1;
            stateN  = RDATA;
          end
        end
        IGNORE: sdaOeN = 1'b0;
        default: stateN = IDLE;
      endcase
    end
  end

  assign I2C_SDAT = sdaOe ? 1'b0 : 1'bz;
  assign regIf.oREG_ADDR  = regAddr;
  assign regIf.oREG_WDATA = wdata;
  assign regIf.oREG_WE    = we;
  assign regIf.oREG_RE    = reC;
  assign regIf.oBUSY      = busy;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C initiator.
// Ports: none; drives iCLK, iRST_N, SCL, SDA and the register read port.
module tb_i2c_reg_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic mDrvLow = 1'b0;
  wire  sda;

  assign sda = mDrvLow ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_slave_if regIf ();
  assign regIf.iREG_RDATA = ~regIf.oREG_ADDR;

  i2c_reg_slave dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda),
    .regIf(regIf.master)
  );

  always #10 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [7:0] weAddr[$];
  logic [7:0] weData[$];
  int reCnt = 0;
  bit both = 0;
  bit busySeen = 0;
  bit slaveDrove = 0;

  always @(negedge clk) begin
    if (regIf.oREG_WE) begin
      weAddr.push_back(regIf.oREG_ADDR);
      weData.push_back(regIf.oREG_WDATA);
    end
    if (regIf.oREG_RE) reCnt++;
    if (regIf.oREG_WE && regIf.oREG_RE) both = 1;
    if (regIf.oBUSY) busySeen = 1;
  end

  always @(posedge clk)
    if (!mDrvLow && sda === 1'b0) slaveDrove = 1;

  task automatic qd;
    repeat (Q) @(negedge clk);
  endtask

  task automatic clr;
    weAddr.delete();
    weData.delete();
    reCnt = 0;
    both = 0;
    busySeen = 0;
    slaveDrove = 0;
  endtask

  task automatic i2cStart;
    mDrvLow = 0; qd();
    scl = 1; qd();
    mDrvLow = 1; qd();
    scl = 0; qd();
  endtask

  task automatic i2cStop;
    mDrvLow = 1; qd();
    scl = 1; qd();
    mDrvLow = 0; qd();
  endtask

  task automatic wrBit(input logic b);
    mDrvLow = ~b; qd();
    scl = 1; qd(); qd();
    scl = 0; qd();
  endtask

  task automatic rdBit(output logic b);
    mDrvLow = 0; qd();
    scl = 1; qd();
    b = sda; qd();
    scl = 0; qd();
  endtask

  task automatic wrByte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) wrBit(v[i]);
    rdBit(ack);
  endtask

  task automatic rdByte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rdBit(b);
      v[i] = b;
    end
    wrBit(nack);
  endtask

  task automatic chk(input string n, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic test_reset;
    chk("rst_addr", regIf.oREG_ADDR, 8'h00);
    chk("rst_wdata", regIf.oREG_WDATA, 8'h00);
    chk("rst_we", {7'd0, regIf.oREG_WE}, 8'h00);
    chk("rst_re", {7'd0, regIf.oREG_RE}, 8'h00);
    chk("rst_busy", {7'd0, regIf.oBUSY}, 8'h00);
    chk("rst_sda", {7'd0, sda}, 8'h01);
  endtask

  task automatic test_write_single;
    logic a0, a1, a2;
    clr();
    i2cStart();
    wrByte(8'h34, a0);
    wrByte(8'h0C, a1);
    wrByte(8'h00, a2);
    chk("ws_ack", {5'd0, a0, a1, a2}, 8'h00);
    chk("ws_busy", {7'd0, regIf.oBUSY}, 8'h01);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("ws_busy_stop", {7'd0, regIf.oBUSY}, 8'h00);
    chk("ws_we_cnt", 8'(weAddr.size()), 8'd1);
    if (weAddr.size() == 1) begin
      chk("ws_addr", weAddr[0], 8'h0C);
      chk("ws_data", weData[0], 8'h00);
    end
  endtask

  task automatic test_burst;
    logic a;
    logic [4:0] acks;
    logic [7:0] ea[3];
    logic [7:0] ed[3];
    logic [7:0] fr[5];
    ea = '{8'hFE, 8'hFF, 8'h00};
    ed = '{8'hA1, 8'hB2, 8'hC3};
    fr = '{8'h34, 8'hFE, 8'hA1, 8'hB2, 8'hC3};
    clr();
    i2cStart();
    for (int i = 0; i < 5; i++) begin
      wrByte(fr[i], a);
      acks[i] = a;
    end
    i2cStop();
    repeat (20) @(negedge clk);
    chk("bw_ack", {3'd0, acks}, 8'h00);
    chk("bw_we_cnt", 8'(weAddr.size()), 8'd3);
    if (weAddr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bw_addr%0d", i), weAddr[i], ea[i]);
        chk($sformatf("bw_data%0d", i), weData[i], ed[i]);
      end
    end
    chk("bw_ptr", regIf.oREG_ADDR, 8'h01);
    chk("bw_both", {7'd0, both}, 8'h00);
  endtask

  task automatic test_mismatch;
    logic a0, a1, a2;
    clr();
    i2cStart();
    wrByte(8'h40, a0);
    wrByte(8'h0F, a1);
    wrByte(8'h80, a2);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("mm_nack", {5'd0, a0, a1, a2}, 8'h07);
    chk("mm_drove", {7'd0, slaveDrove}, 8'h00);
    chk("mm_we_cnt", 8'(weAddr.size()), 8'd0);
    chk("mm_busy", {7'd0, busySeen}, 8'h00);
  endtask

  task automatic test_read;
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    clr();
    i2cStart();
    wrByte(8'h34, a0);
    wrByte(8'h10, a1);
    i2cStart();
    wrByte(8'h35, a2);
    rdByte(b0, 1'b0);
    rdByte(b1, 1'b1);
    chk("rd_ack", {5'd0, a0, a1, a2}, 8'h00);
    chk("rd_byte0", b0, 8'hEF);
    chk("rd_byte1", b1, 8'hEE);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("rd_re_cnt", 8'(reCnt), 8'd2);
    chk("rd_we_cnt", 8'(weAddr.size()), 8'd0);
    chk("rd_sda", {7'd0, sda}, 8'h01);
    chk("rd_both", {7'd0, both}, 8'h00);
  endtask

  task automatic test_glitch;
    logic a;
    logic [7:0] v;
    clr();
    scl = 1;
    mDrvLow = 0;
    qd();
    mDrvLow = 1;
    @(negedge clk);
    mDrvLow = 0;
    qd();
    scl = 0;
    qd();
    v = 8'h34;
    for (int i = 7; i >= 0; i--) wrBit(v[i]);
    rdBit(a);
    chk("gl_nack", {7'd0, a}, 8'h01);
    chk("gl_busy", {7'd0, busySeen}, 8'h00);
    i2cStop();
    clr();
    i2cStart();
    wrByte(8'h34, a);
    wrByte(8'h0C, a);
    for (int i = 0; i < 4; i++) wrBit(1'b1);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("gl_stop_we", 8'(weAddr.size()), 8'd0);
    chk("gl_stop_busy", {7'd0, regIf.oBUSY}, 8'h00);
    i2cStart();
    wrByte(8'h34, a);
    wrByte(8'h20, a);
    wrByte(8'h55, a);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("gl_after_we", 8'(weAddr.size()), 8'd1);
    if (weAddr.size() == 1) begin
      chk("gl_after_addr", weAddr[0], 8'h20);
      chk("gl_after_data", weData[0], 8'h55);
    end
  endtask

  task automatic test_reset_mid;
    logic a0, a1, a2;
    logic [7:0] v;
    clr();
    i2cStart();
    v = 8'h34;
    for (int i = 7; i >= 0; i--) wrBit(v[i]);
    mDrvLow = 0; qd();
    scl = 1; qd();
    chk("rm_ack_drv", {7'd0, sda}, 8'h00);
    rst_n = 0;
    #1;
    chk("rm_sda_rel", {7'd0, sda}, 8'h01);
    repeat (5) @(negedge clk);
    rst_n = 1;
    qd();
    scl = 0; qd(); qd();
    i2cStop();
    clr();
    i2cStart();
    wrByte(8'h34, a0);
    wrByte(8'h30, a1);
    wrByte(8'h77, a2);
    i2cStop();
    repeat (20) @(negedge clk);
    chk("rm_ack", {5'd0, a0, a1, a2}, 8'h00);
    chk("rm_we_cnt", 8'(weAddr.size()), 8'd1);
    if (weAddr.size() == 1) begin
      chk("rm_addr", weAddr[0], 8'h30);
      chk("rm_data", weData[0], 8'h77);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    test_reset();
    rst_n = 1;
    repeat (5) @(negedge clk);
    test_reset();
    test_write_single();
    test_burst();
    test_mismatch();
    test_read();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (responder) for board-level config buses: decodes START/STOP, matches a 7-bit device address, ACKs, and converts write frames {dev_addr+W, sub_addr, data...} into single-cycle register write strobes.
- Serves reads through a register-read port.
- Used as an on-chip register target and as the bus model that the bench config masters talk to (the default address answers 8'h34 write frames).
- Fully synchronous to iCLK. SCL/SDA are oversampled, never used as clocks.

Parameters:
- SLAVE_ADDR, 7'h1A, 7-bit device address matched on bits [7:1] of the first byte.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (range 1-15).

Ports:
- iCLK  in  1  system clock (50 MHz nominal, ≥ 20x SCL rate).
- iRST_N  in  1  asynchronous active-low reset.
- I2C_SCLK  in  1  bus clock from the initiator. The block never stretches SCL.
- I2C_SDAT  inout  1  open-drain data line: driven 0 when the block pulls low, otherwise 1'bz.
- oREG_ADDR  out  8  register pointer (sub-address, auto-incremented).
- oREG_WDATA  out  8  write data, valid while oREG_WE is high.
- oREG_WE  out  1  one-iCLK write strobe.
- oREG_RE  out  1  one-iCLK strobe: iREG_RDATA at oREG_ADDR is captured this cycle.
- iREG_RDATA  in  8  read data, combinational from oREG_ADDR. Must be valid in the cycle oREG_RE is high.
- oBUSY  out  1  high from address match until STOP or START.

Behaviour:
Input conditioning:
- Both lines pass a 2-flop synchronizer, then the FILTER_LEN glitch filter. Filtered values reset to 1.
- Edge events are single-iCLK pulses derived from the filtered values: scl_rise, scl_fall, start (SDA 1->0 while SCL=1), stop (SDA 0->1 while SCL=1).
- Total input latency is 2+FILTER_LEN cycles.

Reset values:
- Outputs: oREG_ADDR=0, oREG_WDATA=0, oREG_WE=0, oREG_RE=0, oBUSY=0, SDA released.
- Internal: state IDLE, bit counter 0.
- An asserted reset mid-transfer releases SDA immediately (asynchronously).

Global rules:
- START in any state: release SDA, clear bit counter, go to ADDR. This covers repeated START.
- STOP in any state: release SDA, go to IDLE, oBUSY=0. The pointer is retained.
- Data bits are sampled MSB-first on scl_rise. SDA drive changes only on scl_fall.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits. On the 8th scl_rise, compare [7:1] with SLAVE_ADDR.
  - Match: set oBUSY=1 and latch the R/W bit.
  - Mismatch: go to IGNORE (SDA never driven).
- ADDR_ACK: on the next scl_fall, pull SDA low; release it on the following scl_fall (end of the 9th clock).
  - R/W=0: go to SUB.
  - R/W=1: in the same scl_fall cycle that releases ACK, pulse oREG_RE, load iREG_RDATA into the TX shifter, drive its MSB, and go to RDATA.
- SUB: shift 8 bits. On the 8th scl_rise, set oREG_ADDR to the received byte, then go to SUB_ACK (ACK as above), then WDATA.
- WDATA: shift 8 bits. On the 8th scl_rise:
  - set oREG_WDATA to the byte and pulse oREG_WE for 1 cycle with the current oREG_ADDR;
  - increment oREG_ADDR in the next cycle, wrapping 8'hFF->8'h00;
  - ACK, then return to WDATA for further bytes.
- RDATA: drive bit n on each scl_fall. Drive 0 = pull low; drive 1 = release. On the 8th scl_fall, release SDA and go to MACK.
- MACK: on scl_rise, sample SDA.
  - 0 (master ACK): increment oREG_ADDR with wrap. On the next scl_fall, pulse oREG_RE, load the next byte, drive its MSB, and go to RDATA.
  - 1 (NACK): go to IGNORE.
- IGNORE: SDA released. Wait for START or STOP.

Boundary conditions:
- A frame ending after SUB (no data byte) only sets the pointer. This is the write-pointer-then-repeated-START-read sequence.
- STOP or START arriving mid-byte discards the partial byte: no strobe is generated.
- scl_rise and a start/stop event never occur in the same cycle. If they do, start/stop wins.
- oREG_WE and oREG_RE are never high together.

Test Plan:
- Write frame 8'h34, 8'h0C, 8'h00, STOP -> ACK low on all 3 ninth clocks; exactly one oREG_WE with oREG_ADDR=8'h0C and oREG_WDATA=8'h00; oBUSY falls at STOP.
- Burst write 8'h34, 8'hFE, 8'hA1, 8'hB2, 8'hC3 -> three WE strobes at addresses FE, FF, 00 with data A1, B2, C3 (pointer wrap).
- Address mismatch 8'h40, 8'h0F, 8'h80 -> SDA never driven (NACK seen by the initiator), no strobes, oBUSY stays 0.
- Read: write 8'h34, 8'h10, then repeated START, 8'h35, with iREG_RDATA=~oREG_ADDR -> bytes EF, EE returned MSB-first; master NACK on the 2nd byte; SDA released; 2 oREG_RE pulses.
- Glitch: 1-cycle SDA low pulse while SCL high, with FILTER_LEN=3 -> no START detected. STOP inserted after 4 data bits -> no WE, state IDLE.
- iRST_N asserted while the ACK is being driven -> SDA goes to z immediately; after release, the block is IDLE and the next valid frame is ACKed.
